// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - state, opcode and datapath-select encodings for the multicycle MIPS controller
package mips_ctrl_pkg;

   // Controller states; encodings 14 and 15 are illegal and recover to FETCH
   typedef enum logic [3:0] {
      RST       = 4'd0,
      FETCH     = 4'd1,
      DECODE    = 4'd2,
      MEM_ADDR  = 4'd3,
      MEM_READ  = 4'd4,
      MEM_WB    = 4'd5,
      MEM_WRITE = 4'd6,
      R_EXEC    = 4'd7,
      R_WB      = 4'd8,
      ADDI_EXEC = 4'd9,
      ADDI_WB   = 4'd10,
      BRANCH    = 4'd11,
      JUMP      = 4'd12,
      TRAP      = 4'd13
   } state_t;

   // Decoded opcodes (IR[31:26])
   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_ADDI = 6'h08;

   // ALUOp encodings
   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_SUB   = 2'd1;
   localparam logic [1:0] ALUOP_FUNCT = 2'd2;

   // ALUSrcB encodings
   localparam logic [1:0] SRCB_RT     = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   // PCSource encodings
   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;
   localparam logic [1:0] PCSRC_EXC    = 2'd3;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - controller <-> datapath bus (opcode/flags in, selects/enables out)
interface mips_multicycle_ctrl_if #(
   parameter int OPCODE_W = 6,
   parameter int ALUOP_W  = 2
);
   logic [OPCODE_W-1:0] Opcode;
   logic                Zero;
   logic                Overflow;
   logic                Load_PC;
   logic                PCWriteCond;
   logic                Empty_PC;
   logic [1:0]          PCSource;
   logic                IorD;
   logic                MemWrite;
   logic                IRWrite;
   logic                RegWrite;
   logic                RegDst;
   logic                MemtoReg;
   logic                ALUSrcA;
   logic [1:0]          ALUSrcB;
   logic [ALUOP_W-1:0]  ALUOp;
   logic                EPCWrite;
   logic [3:0]          State;

   // Controller side
   modport master (
      input  Opcode, Zero, Overflow,
      output Load_PC, PCWriteCond, Empty_PC, PCSource, IorD, MemWrite, IRWrite,
             RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, EPCWrite, State
   );

   // Datapath side
   modport slave (
      output Opcode, Zero, Overflow,
      input  Load_PC, PCWriteCond, Empty_PC, PCSource, IorD, MemWrite, IRWrite,
             RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, EPCWrite, State
   );
endinterface

// File: rtl/mips_ctrl_wait_cnt.sv
// rtl/mips_ctrl_wait_cnt.sv - memory-latency wait counter with clear, increment and done flag
module mips_ctrl_wait_cnt #(
   parameter int CNT_W   = 4,
   parameter int MEM_LAT = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_done
);
   logic [CNT_W-1:0] r_cnt;

   // Count memory wait cycles; clear wins over increment
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_done = (r_cnt == CNT_W'(MEM_LAT - 1));
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM; MIPS_CTRL_OVF_TRAP_EN enables the overflow trap
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int ALUOP_W  = 2,
   parameter int MEM_LAT  = 1,
   parameter int CNT_W    = 4
) (
   input logic                   Clk,
   input logic                   Reset_PC,
   mips_multicycle_ctrl_if.master bus
);
   state_t     r_state;
   logic       w_cnt_done;
   logic       w_wait_state;
   logic       w_load_pc, w_pcwc, w_empty_pc, w_iord, w_memwrite, w_irwrite;
   logic       w_regwrite, w_regdst, w_memtoreg, w_srca, w_epcwrite;
   logic [1:0] w_pcsource, w_srcb, w_aluop;
   logic       w_unused_flags;

   // FETCH and MEM_READ are the only states that wait on memory
   assign w_wait_state = (r_state == FETCH) || (r_state == MEM_READ);

   mips_ctrl_wait_cnt #(
      .CNT_W  (CNT_W),
      .MEM_LAT(MEM_LAT)
   ) u_wait_cnt (
      .i_clk  (Clk),
      .i_rst_n(Reset_PC),
      .i_clr  (w_wait_state && w_cnt_done),
      .i_inc  (w_wait_state && !w_cnt_done),
      .o_done (w_cnt_done)
   );

   // State register: sequences fetch/decode/execute/memory/writeback
   always_ff @(posedge Clk or negedge Reset_PC) begin
      if (!Reset_PC) begin
         r_state <= RST;
      end else begin
         case (r_state)
            RST:       r_state <= FETCH;
            FETCH:     if (w_cnt_done) r_state <= DECODE;
            DECODE: begin
               if (bus.Opcode == OPCODE_W'(OP_R))         r_state <= R_EXEC;
               else if (bus.Opcode == OPCODE_W'(OP_LW) ||
                        bus.Opcode == OPCODE_W'(OP_SW))   r_state <= MEM_ADDR;
               else if (bus.Opcode == OPCODE_W'(OP_BEQ))  r_state <= BRANCH;
               else if (bus.Opcode == OPCODE_W'(OP_J))    r_state <= JUMP;
               else if (bus.Opcode == OPCODE_W'(OP_ADDI)) r_state <= ADDI_EXEC;
               else                                       r_state <= FETCH;
            end
            MEM_ADDR: begin
               if (bus.Opcode == OPCODE_W'(OP_LW))       r_state <= MEM_READ;
               else if (bus.Opcode == OPCODE_W'(OP_SW))  r_state <= MEM_WRITE;
               else                                      r_state <= FETCH;
            end
            MEM_READ:  if (w_cnt_done) r_state <= MEM_WB;
            R_EXEC:    r_state <= R_WB;
            ADDI_EXEC: r_state <= ADDI_WB;
`ifdef MIPS_CTRL_OVF_TRAP_EN
            R_WB, ADDI_WB: r_state <= bus.Overflow ? TRAP : FETCH;
            TRAP:          r_state <= FETCH;
`else
            R_WB, ADDI_WB: r_state <= FETCH;
`endif
            MEM_WB, MEM_WRITE, BRANCH, JUMP: r_state <= FETCH;
            default:   r_state <= FETCH;
         endcase
      end
   end

   // Output decoder: selects and enables from state and wait count
   always_comb begin
      w_load_pc  = 1'b0;
      w_pcwc     = 1'b0;
      w_empty_pc = 1'b0;
      w_pcsource = PCSRC_ALU;
      w_iord     = 1'b0;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      w_regwrite = 1'b0;
      w_regdst   = 1'b0;
      w_memtoreg = 1'b0;
      w_srca     = 1'b0;
      w_srcb     = SRCB_RT;
      w_aluop    = ALUOP_ADD;
      w_epcwrite = 1'b0;
      case (r_state)
         RST:       w_empty_pc = 1'b1;
         FETCH: begin
            w_srcb    = SRCB_FOUR;
            w_irwrite = w_cnt_done;
            w_load_pc = w_cnt_done;
         end
         DECODE:    w_srcb = SRCB_IMM_SH;
         MEM_ADDR: begin
            w_srca = 1'b1;
            w_srcb = SRCB_IMM;
         end
         MEM_READ:  w_iord = 1'b1;
         MEM_WB: begin
            w_regwrite = 1'b1;
            w_memtoreg = 1'b1;
         end
         MEM_WRITE: begin
            w_iord     = 1'b1;
            w_memwrite = 1'b1;
         end
         R_EXEC: begin
            w_srca  = 1'b1;
            w_aluop = ALUOP_FUNCT;
         end
         R_WB: begin
`ifdef MIPS_CTRL_OVF_TRAP_EN
            w_regwrite = !bus.Overflow;
`else
            w_regwrite = 1'b1;
`endif
            w_regdst   = 1'b1;
         end
         ADDI_EXEC: begin
            w_srca = 1'b1;
            w_srcb = SRCB_IMM;
         end
         ADDI_WB: begin
`ifdef MIPS_CTRL_OVF_TRAP_EN
            w_regwrite = !bus.Overflow;
`else
            w_regwrite = 1'b1;
`endif
         end
         BRANCH: begin
            w_srca     = 1'b1;
            w_aluop    = ALUOP_SUB;
            w_pcwc     = 1'b1;
            w_pcsource = PCSRC_ALUOUT;
         end
         JUMP: begin
            w_load_pc  = 1'b1;
            w_pcsource = PCSRC_JUMP;
         end
`ifdef MIPS_CTRL_OVF_TRAP_EN
         TRAP: begin
            w_epcwrite = 1'b1;
            w_load_pc  = 1'b1;
            w_pcsource = PCSRC_EXC;
         end
`endif
         default: ;
      endcase
   end

   // Zero is consumed by the datapath PC-write gating, not by the sequencer
`ifdef MIPS_CTRL_OVF_TRAP_EN
   assign w_unused_flags = bus.Zero;
`else
   assign w_unused_flags = bus.Zero ^ bus.Overflow;
`endif

   assign bus.Load_PC     = w_load_pc;
   assign bus.PCWriteCond = w_pcwc;
   assign bus.Empty_PC    = w_empty_pc;
   assign bus.PCSource    = w_pcsource;
   assign bus.IorD        = w_iord;
   assign bus.MemWrite    = w_memwrite;
   assign bus.IRWrite     = w_irwrite;
   assign bus.RegWrite    = w_regwrite;
   assign bus.RegDst      = w_regdst;
   assign bus.MemtoReg    = w_memtoreg;
   assign bus.ALUSrcA     = w_srca;
   assign bus.ALUSrcB     = w_srcb;
   assign bus.ALUOp       = ALUOP_W'(w_aluop);
   assign bus.EPCWrite    = w_epcwrite;
   assign bus.State       = r_state;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard bench for the multicycle MIPS controller (MEM_LAT=1 and 3)
module tb_mips_multicycle_ctrl;
   import mips_ctrl_pkg::*;

   // {Load_PC,PCWriteCond,Empty_PC,PCSource,IorD,MemWrite,IRWrite,RegWrite,RegDst,MemtoReg,ALUSrcA,ALUSrcB,ALUOp,EPCWrite}
   function automatic logic [16:0] mk(input logic ld, input logic pcwc, input logic emp,
                                      input logic [1:0] pcs, input logic iord, input logic mw,
                                      input logic irw, input logic rw, input logic rd,
                                      input logic m2r, input logic sa, input logic [1:0] sb,
                                      input logic [1:0] op, input logic epc);
      return {ld, pcwc, emp, pcs, iord, mw, irw, rw, rd, m2r, sa, sb, op, epc};
   endfunction

   localparam logic [16:0] E_RST  = mk(0,0,1,0, 0,0,0,0,0,0, 0,0,0,0);
   localparam logic [16:0] E_FW   = mk(0,0,0,0, 0,0,0,0,0,0, 0,1,0,0);
   localparam logic [16:0] E_FD   = mk(1,0,0,0, 0,0,1,0,0,0, 0,1,0,0);
   localparam logic [16:0] E_DEC  = mk(0,0,0,0, 0,0,0,0,0,0, 0,3,0,0);
   localparam logic [16:0] E_MADR = mk(0,0,0,0, 0,0,0,0,0,0, 1,2,0,0);
   localparam logic [16:0] E_MRD  = mk(0,0,0,0, 1,0,0,0,0,0, 0,0,0,0);
   localparam logic [16:0] E_MWB  = mk(0,0,0,0, 0,0,0,1,0,1, 0,0,0,0);
   localparam logic [16:0] E_MWR  = mk(0,0,0,0, 1,1,0,0,0,0, 0,0,0,0);
   localparam logic [16:0] E_REX  = mk(0,0,0,0, 0,0,0,0,0,0, 1,0,2,0);
   localparam logic [16:0] E_RWB  = mk(0,0,0,0, 0,0,0,1,1,0, 0,0,0,0);
   localparam logic [16:0] E_AEX  = mk(0,0,0,0, 0,0,0,0,0,0, 1,2,0,0);
   localparam logic [16:0] E_AWB  = mk(0,0,0,0, 0,0,0,1,0,0, 0,0,0,0);
   localparam logic [16:0] E_BR   = mk(0,1,0,1, 0,0,0,0,0,0, 1,0,1,0);
   localparam logic [16:0] E_JMP  = mk(1,0,0,2, 0,0,0,0,0,0, 0,0,0,0);
   localparam logic [16:0] E_TRAP = mk(1,0,0,3, 0,0,0,0,0,0, 0,0,0,1);
   localparam logic [16:0] E_NONE = 17'd0;

   typedef struct {
      logic       r;
      logic [5:0] op;
      logic       z;
      logic       o;
      state_t     st;
      logic [16:0] c;
   } vec_t;

   typedef struct {
      state_t      st;
      logic [16:0] c;
   } exp_t;

   logic        Clk;
   logic        rst1, rst3;
   int          n_checks, n_fail;
   vec_t        vq[$];
   exp_t        q1[$], q3[$];
   exp_t        e1, e3;
   logic [16:0] w_ctl1, w_ctl3;

   mips_multicycle_ctrl_if #(.OPCODE_W(6), .ALUOP_W(2)) bus1();
   mips_multicycle_ctrl_if #(.OPCODE_W(6), .ALUOP_W(2)) bus3();

   mips_multicycle_ctrl #(.OPCODE_W(6), .ALUOP_W(2), .MEM_LAT(1), .CNT_W(4)) u_dut1 (
      .Clk(Clk), .Reset_PC(rst1), .bus(bus1)
   );
   mips_multicycle_ctrl #(.OPCODE_W(6), .ALUOP_W(2), .MEM_LAT(3), .CNT_W(4)) u_dut3 (
      .Clk(Clk), .Reset_PC(rst3), .bus(bus3)
   );

   assign w_ctl1 = {bus1.Load_PC, bus1.PCWriteCond, bus1.Empty_PC, bus1.PCSource, bus1.IorD,
                    bus1.MemWrite, bus1.IRWrite, bus1.RegWrite, bus1.RegDst, bus1.MemtoReg,
                    bus1.ALUSrcA, bus1.ALUSrcB, bus1.ALUOp, bus1.EPCWrite};
   assign w_ctl3 = {bus3.Load_PC, bus3.PCWriteCond, bus3.Empty_PC, bus3.PCSource, bus3.IorD,
                    bus3.MemWrite, bus3.IRWrite, bus3.RegWrite, bus3.RegDst, bus3.MemtoReg,
                    bus3.ALUSrcA, bus3.ALUSrcB, bus3.ALUOp, bus3.EPCWrite};

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic add(input logic r, input logic [5:0] op, input logic z, input logic o,
                      input state_t st, input logic [16:0] c);
      vec_t v;
      v.r = r; v.op = op; v.z = z; v.o = o; v.st = st; v.c = c;
      vq.push_back(v);
   endtask

   task automatic check(input int d, input exp_t e, input logic [3:0] st, input logic [16:0] c);
      n_checks++;
      if (st !== e.st) begin
         n_fail++;
         $display("FAIL dut%0d state: got %0d expected %0d", d, st, e.st);
      end
      n_checks++;
      if (c !== e.c) begin
         n_fail++;
         $display("FAIL dut%0d outputs in state %0d: got %b expected %b", d, e.st, c, e.c);
      end
   endtask

   // Drive one vector per cycle just after the rising edge; queue the response expected this cycle
   task automatic run(input int which);
      vec_t v;
      exp_t e;
      while (vq.size() > 0) begin
         v = vq.pop_front();
         @(posedge Clk);
         #1;
         e.st = v.st;
         e.c  = v.c;
         if (which == 3) begin
            rst1 = 1'b0;
            rst3 = v.r;
            bus3.Opcode = v.op; bus3.Zero = v.z; bus3.Overflow = v.o;
            q3.push_back(e);
         end else begin
            rst3 = 1'b0;
            rst1 = v.r;
            bus1.Opcode = v.op; bus1.Zero = v.z; bus1.Overflow = v.o;
            q1.push_back(e);
         end
      end
   endtask

   always @(negedge Clk) begin
      if (q1.size() > 0) begin
         e1 = q1.pop_front();
         check(1, e1, bus1.State, w_ctl1);
      end
   end

   always @(negedge Clk) begin
      if (q3.size() > 0) begin
         e3 = q3.pop_front();
         check(3, e3, bus3.State, w_ctl3);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst1 = 1'b0; rst3 = 1'b0;
      bus1.Opcode = '0; bus1.Zero = 1'b0; bus1.Overflow = 1'b0;
      bus3.Opcode = '0; bus3.Zero = 1'b0; bus3.Overflow = 1'b0;

      // MEM_LAT=3: LW (10 cycles from reset release), SW, LW cut by reset in MEM_READ, unknown opcode
      add(0, 6'h23, 0, 0, RST, E_RST);
      add(1, 6'h23, 0, 0, RST, E_RST);
      add(1, 6'h23, 0, 0, FETCH, E_FW);
      add(1, 6'h23, 0, 0, FETCH, E_FW);
      add(1, 6'h23, 0, 0, FETCH, E_FD);
      add(1, 6'h23, 0, 0, DECODE, E_DEC);
      add(1, 6'h23, 0, 0, MEM_ADDR, E_MADR);
      add(1, 6'h23, 0, 0, MEM_READ, E_MRD);
      add(1, 6'h23, 0, 0, MEM_READ, E_MRD);
      add(1, 6'h23, 0, 0, MEM_READ, E_MRD);
      add(1, 6'h23, 0, 0, MEM_WB, E_MWB);
      add(1, 6'h2B, 0, 0, FETCH, E_FW);
      add(1, 6'h2B, 0, 0, FETCH, E_FW);
      add(1, 6'h2B, 0, 0, FETCH, E_FD);
      add(1, 6'h2B, 0, 0, DECODE, E_DEC);
      add(1, 6'h2B, 0, 0, MEM_ADDR, E_MADR);
      add(1, 6'h2B, 0, 0, MEM_WRITE, E_MWR);
      add(1, 6'h23, 0, 0, FETCH, E_FW);
      add(1, 6'h23, 0, 0, FETCH, E_FW);
      add(1, 6'h23, 0, 0, FETCH, E_FD);
      add(1, 6'h23, 0, 0, DECODE, E_DEC);
      add(1, 6'h23, 0, 0, MEM_ADDR, E_MADR);
      add(1, 6'h23, 0, 0, MEM_READ, E_MRD);
      add(0, 6'h23, 0, 0, RST, E_RST);
      add(1, 6'h3F, 0, 0, RST, E_RST);
      add(1, 6'h3F, 0, 0, FETCH, E_FW);
      add(1, 6'h3F, 0, 0, FETCH, E_FW);
      add(1, 6'h3F, 0, 0, FETCH, E_FD);
      add(1, 6'h3F, 0, 0, DECODE, E_DEC);
      add(1, 6'h3F, 0, 0, FETCH, E_FW);
      run(3);

      // MEM_LAT=1: R-type, BEQ, J, ADDI, ADDI with overflow
      add(0, 6'h00, 0, 0, RST, E_RST);
      add(1, 6'h00, 0, 0, RST, E_RST);
      add(1, 6'h00, 0, 0, FETCH, E_FD);
      add(1, 6'h00, 0, 0, DECODE, E_DEC);
      add(1, 6'h00, 0, 0, R_EXEC, E_REX);
      add(1, 6'h00, 0, 0, R_WB, E_RWB);
      add(1, 6'h04, 1, 0, FETCH, E_FD);
      add(1, 6'h04, 1, 0, DECODE, E_DEC);
      add(1, 6'h04, 1, 0, BRANCH, E_BR);
      add(1, 6'h02, 0, 0, FETCH, E_FD);
      add(1, 6'h02, 0, 0, DECODE, E_DEC);
      add(1, 6'h02, 0, 0, JUMP, E_JMP);
      add(1, 6'h08, 0, 0, FETCH, E_FD);
      add(1, 6'h08, 0, 0, DECODE, E_DEC);
      add(1, 6'h08, 0, 0, ADDI_EXEC, E_AEX);
      add(1, 6'h08, 0, 0, ADDI_WB, E_AWB);
      add(1, 6'h08, 0, 1, FETCH, E_FD);
      add(1, 6'h08, 0, 1, DECODE, E_DEC);
      add(1, 6'h08, 0, 1, ADDI_EXEC, E_AEX);
`ifdef MIPS_CTRL_OVF_TRAP_EN
      add(1, 6'h08, 0, 1, ADDI_WB, E_NONE);
      add(1, 6'h3F, 0, 0, TRAP, E_TRAP);
`else
      add(1, 6'h08, 0, 1, ADDI_WB, E_AWB);
`endif
      add(1, 6'h3F, 0, 0, FETCH, E_FD);
      add(1, 6'h3F, 0, 0, DECODE, E_DEC);
      add(1, 6'h3F, 0, 0, FETCH, E_FD);
      run(1);

      repeat (2) @(posedge Clk);
      n_checks++;
      if (q1.size() + q3.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard drain: got %0d pending expected 0", q1.size() + q3.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
